// File: rtl/guess_scorer_if.sv
// Guess-submission handshake between the guess/history initiator and the scorer.
interface guess_scorer_if #(parameter int COLOR_W = 3);
  logic               guess_valid;
  logic               guess_ready;
  logic [COLOR_W-1:0] guess0;
  logic [COLOR_W-1:0] guess1;
  logic [COLOR_W-1:0] guess2;
  logic [COLOR_W-1:0] guess3;

  modport master (output guess_valid, guess0, guess1, guess2, guess3, input guess_ready);
  modport slave  (input guess_valid, guess0, guess1, guess2, guess3, output guess_ready);
endinterface

// File: rtl/guess_scorer.sv
// Mastermind guess scorer: one exact pass, then one colour-match step per guess peg.
// Optional macro SCORER_SORT_FEEDBACK_EN reports fb0..fb3 sorted (2s, then 1s, then 0s).
module guess_scorer #(
  parameter int COLOR_W   = 3,
  parameter int MAX_TURNS = 8,
  parameter int TURN_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               code_load,
  input  logic [COLOR_W-1:0] code0,
  input  logic [COLOR_W-1:0] code1,
  input  logic [COLOR_W-1:0] code2,
  input  logic [COLOR_W-1:0] code3,
  guess_scorer_if.slave      gif,
  output logic               result_valid,
  output logic [2:0]         exact_cnt,
  output logic [2:0]         color_cnt,
  output logic [1:0]         fb0,
  output logic [1:0]         fb1,
  output logic [1:0]         fb2,
  output logic [1:0]         fb3,
  output logic [TURN_W-1:0]  turn,
  output logic               game_won,
  output logic               game_over
);
  localparam logic [TURN_W-1:0] MAX_T = TURN_W'(MAX_TURNS);

  typedef enum logic [1:0] {IDLE, EXACT, COLOR, DONE} state_t;

  state_t                    state, state_nx;
  logic                      code_loaded;
  logic                      accept;
  logic [3:0][COLOR_W-1:0]   code_r;
  logic [3:0][COLOR_W-1:0]   g_reg;
  logic [3:0]                code_used;
  logic [3:0]                guess_used;
  logic [3:0]                ex_vec;
  logic [1:0]                idx;
  logic [2:0]                ex_acc;
  logic [2:0]                col_acc;
  logic [3:0][1:0]           fb_work;
  logic [3:0][1:0]           fb_out;
  logic                      hit;
  logic [1:0]                hit_j;

  function automatic logic [2:0] count4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [TURN_W-1:0] sat_inc(input logic [TURN_W-1:0] t);
    return (t == MAX_T) ? t : t + TURN_W'(1);
  endfunction

`ifdef SCORER_SORT_FEEDBACK_EN
  function automatic logic [3:0][1:0] sort_fb(input logic [2:0] ex, input logic [2:0] col);
    logic [3:0][1:0] r;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(ex))                r[i] = 2'd2;
      else if (i < int'(ex) + int'(col)) r[i] = 2'd1;
      else                             r[i] = 2'd0;
    end
    return r;
  endfunction
`endif

  assign gif.guess_ready = (state == IDLE) && code_loaded && !game_over;
  assign {fb3, fb2, fb1, fb0} = fb_out;

  always_comb begin
    for (int i = 0; i < 4; i++) ex_vec[i] = (g_reg[i] == code_r[i]);
    // Descending search so the lowest free matching code index wins.
    hit   = 1'b0;
    hit_j = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (!code_used[j] && code_r[j] == g_reg[idx]) begin
        hit   = !guess_used[idx];
        hit_j = j[1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (!code_load && gif.guess_valid && gif.guess_ready) begin
        accept   = 1'b1;
        state_nx = EXACT;
      end
      EXACT: state_nx = COLOR;
      COLOR: if (idx == 2'd3) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (code_load) state_nx = IDLE;
  end

  // Control and visible results
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      code_loaded  <= 1'b0;
      result_valid <= 1'b0;
      exact_cnt    <= '0;
      color_cnt    <= '0;
      fb_out       <= '0;
      turn         <= '0;
      game_won     <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nx;
      result_valid <= 1'b0;
      if (code_load) begin
        code_loaded <= 1'b1;
        exact_cnt   <= '0;
        color_cnt   <= '0;
        fb_out      <= '0;
        turn        <= '0;
        game_won    <= 1'b0;
        game_over   <= 1'b0;
      end else if (state == DONE) begin
        result_valid <= 1'b1;
        exact_cnt    <= ex_acc;
        color_cnt    <= col_acc;
`ifdef SCORER_SORT_FEEDBACK_EN
        fb_out       <= sort_fb(ex_acc, col_acc);
`else
        fb_out       <= fb_work;
`endif
        turn         <= sat_inc(turn);
        game_won     <= (ex_acc == 3'd4);
        game_over    <= (ex_acc == 3'd4) || (sat_inc(turn) == MAX_T);
      end
    end
  end

  // Scoring datapath
  always_ff @(posedge clk) begin
    if (code_load) code_r <= {code3, code2, code1, code0};
    if (accept) begin
      g_reg <= {gif.guess3, gif.guess2, gif.guess1, gif.guess0};
      idx   <= 2'd0;
    end
    case (state)
      EXACT: begin
        for (int i = 0; i < 4; i++) fb_work[i] <= ex_vec[i] ? 2'd2 : 2'd0;
        code_used  <= ex_vec;
        guess_used <= ex_vec;
        ex_acc     <= count4(ex_vec);
        col_acc    <= 3'd0;
      end
      COLOR: begin
        if (hit) begin
          fb_work[idx]     <= 2'd1;
          code_used[hit_j] <= 1'b1;
          col_acc          <= col_acc + 3'd1;
        end
        idx <= idx + 2'd1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: directed Mastermind cases plus randomized games
// scored by a count-based reference model.
module tb_guess_scorer;
  logic       clk = 1'b0;
  logic       reset;
  logic       code_load;
  logic [2:0] code0, code1, code2, code3;
  logic       result_valid;
  logic [2:0] exact_cnt, color_cnt;
  logic [1:0] fb0, fb1, fb2, fb3;
  logic [3:0] turn;
  logic       game_won, game_over;

  int total = 0;
  int bad   = 0;

  guess_scorer_if #(.COLOR_W(3)) gif();

  guess_scorer #(.COLOR_W(3), .MAX_TURNS(8), .TURN_W(4)) dut (
    .clk(clk), .reset(reset), .code_load(code_load),
    .code0(code0), .code1(code1), .code2(code2), .code3(code3),
    .gif(gif),
    .result_valid(result_valid), .exact_cnt(exact_cnt), .color_cnt(color_cnt),
    .fb0(fb0), .fb1(fb1), .fb2(fb2), .fb3(fb3),
    .turn(turn), .game_won(game_won), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference: counts from colour histograms; feedback digits from the consumption rule.
  task automatic model_score(input int c[4], input int g[4], output int ex, output int col,
                             output logic [7:0] fbv);
    int hc[8], hg[8], tot, fb[4];
    bit cu[4], gu[4], found;
    ex = 0; tot = 0;
    for (int k = 0; k < 8; k++) begin hc[k] = 0; hg[k] = 0; end
    for (int i = 0; i < 4; i++) begin
      hc[c[i]]++; hg[g[i]]++;
      cu[i] = (c[i] == g[i]); gu[i] = cu[i];
      fb[i] = cu[i] ? 2 : 0;
      if (cu[i]) ex++;
    end
    for (int k = 0; k < 8; k++) tot += (hc[k] < hg[k]) ? hc[k] : hg[k];
    col = tot - ex;
    for (int i = 0; i < 4; i++) begin
      found = 0;
      for (int j = 0; j < 4; j++)
        if (!gu[i] && !found && !cu[j] && c[j] == g[i]) begin
          found = 1; cu[j] = 1; fb[i] = 1;
        end
    end
`ifdef SCORER_SORT_FEEDBACK_EN
    for (int i = 0; i < 4; i++) fb[i] = (i < ex) ? 2 : (i < ex + col) ? 1 : 0;
`endif
    fbv = {2'(fb[3]), 2'(fb[2]), 2'(fb[1]), 2'(fb[0])};
  endtask

  task automatic load_code(input int c[4]);
    code0 = 3'(c[0]); code1 = 3'(c[1]); code2 = 3'(c[2]); code3 = 3'(c[3]);
    code_load = 1'b1;
    @(posedge clk); #1;
    code_load = 1'b0;
  endtask

  // Waits for ready, submits one guess, returns cycles from accept edge to result_valid (-1 if none).
  task automatic do_guess(input int g[4], output int lat);
    int k;
    lat = -1; k = 0;
    while (!gif.guess_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!gif.guess_ready) return;
    gif.guess0 = 3'(g[0]); gif.guess1 = 3'(g[1]);
    gif.guess2 = 3'(g[2]); gif.guess3 = 3'(g[3]);
    gif.guess_valid = 1'b1;
    @(posedge clk); #1;
    gif.guess_valid = 1'b0;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (result_valid) lat = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; code_load = 1'b0; gif.guess_valid = 1'b0;
    code0 = '0; code1 = '0; code2 = '0; code3 = '0;
    gif.guess0 = '0; gif.guess1 = '0; gif.guess2 = '0; gif.guess3 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({result_valid, exact_cnt, color_cnt, fb3, fb2, fb1, fb0, turn, game_won, game_over} !== '0) begin
      bad++; $display("FAIL reset_outputs got rv=%0d ex=%0d col=%0d fb=%h turn=%0d won=%0d over=%0d want all 0",
                      result_valid, exact_cnt, color_cnt, {fb3, fb2, fb1, fb0}, turn, game_won, game_over);
    end
    total++;
    if (gif.guess_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %0d want 0", gif.guess_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Scores one guess against the model; expected turn/over supplied by caller.
  task automatic test_directed_case(input string name, input int c[4], input int g[4],
                                    input int exp_turn);
    int lat, ex, col; logic [7:0] efb;
    model_score(c, g, ex, col, efb);
    do_guess(g, lat);
    total++;
    if (lat !== 6) begin bad++; $display("FAIL %s latency got %0d want 6", name, lat); end
    total++;
    if (exact_cnt !== 3'(ex) || color_cnt !== 3'(col)) begin
      bad++; $display("FAIL %s counts got ex=%0d col=%0d want ex=%0d col=%0d", name, exact_cnt, color_cnt, ex, col);
    end
    total++;
    if ({fb3, fb2, fb1, fb0} !== efb) begin
      bad++; $display("FAIL %s fb got %h want %h", name, {fb3, fb2, fb1, fb0}, efb);
    end
    total++;
    if (turn !== 4'(exp_turn) || game_won !== (ex == 4) || game_over !== (ex == 4 || exp_turn == 8)) begin
      bad++; $display("FAIL %s flags got turn=%0d won=%0d over=%0d want turn=%0d won=%0d", name,
                      turn, game_won, game_over, exp_turn, ex == 4);
    end
  endtask

  task automatic test_directed();
    load_code('{1, 2, 3, 4});
    test_directed_case("win", '{1, 2, 3, 4}, '{1, 2, 3, 4}, 1);
    total++;
    if (gif.guess_ready !== 1'b0 || {exact_cnt, color_cnt, fb3, fb2, fb1, fb0} !== {3'd4, 3'd0, 8'hAA}) begin
      bad++; $display("FAIL win_const got ready=%0d ex=%0d col=%0d fb=%h want ready=0 ex=4 col=0 fb=aa",
                      gif.guess_ready, exact_cnt, color_cnt, {fb3, fb2, fb1, fb0});
    end
    load_code('{1, 2, 3, 4});
    test_directed_case("reverse", '{1, 2, 3, 4}, '{4, 3, 2, 1}, 1);
    load_code('{1, 1, 2, 2});
    test_directed_case("dup_a", '{1, 1, 2, 2}, '{1, 2, 1, 5}, 1);
    test_directed_case("dup_b", '{1, 1, 2, 2}, '{5, 2, 1, 1}, 2);
  endtask

  task automatic test_random();
    int c[4], g[4], t, lat, ex, col; logic [7:0] efb;
    bit over;
    over = 1;
    t = 0;
    for (int n = 0; n < 40; n++) begin
      if (over) begin
        for (int i = 0; i < 4; i++) c[i] = $urandom_range(0, (n % 3 == 0) ? 7 : 3);
        load_code(c);
        t = 0;
      end
      for (int i = 0; i < 4; i++) g[i] = $urandom_range(0, (n % 2 == 0) ? 7 : 3);
      model_score(c, g, ex, col, efb);
      do_guess(g, lat);
      t++;
      over = (ex == 4) || (t == 8);
      total++;
      if (lat !== 6 || exact_cnt !== 3'(ex) || color_cnt !== 3'(col) || {fb3, fb2, fb1, fb0} !== efb
          || turn !== 4'(t) || game_won !== (ex == 4) || game_over !== over) begin
        bad++;
        $display("FAIL random_%0d got lat=%0d ex=%0d col=%0d fb=%h turn=%0d over=%0d want lat=6 ex=%0d col=%0d fb=%h turn=%0d over=%0d",
                 n, lat, exact_cnt, color_cnt, {fb3, fb2, fb1, fb0}, turn, game_over, ex, col, efb, t, over);
      end
    end
  endtask

  task automatic test_turn_limit();
    int lat, pulses;
    load_code('{1, 2, 3, 4});
    for (int k = 1; k <= 8; k++) begin
      do_guess('{7, 7, 7, 7}, lat);
      total++;
      if (lat !== 6 || exact_cnt !== 3'd0 || color_cnt !== 3'd0 || turn !== 4'(k) || game_over !== (k == 8)) begin
        bad++; $display("FAIL turn_%0d got lat=%0d ex=%0d col=%0d turn=%0d over=%0d want lat=6 ex=0 col=0 turn=%0d over=%0d",
                        k, lat, exact_cnt, color_cnt, turn, game_over, k, k == 8);
      end
    end
    gif.guess_valid = 1'b1;
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (result_valid) pulses++; end
    gif.guess_valid = 1'b0;
    total++;
    if (pulses !== 0 || gif.guess_ready !== 1'b0 || turn !== 4'd8) begin
      bad++; $display("FAIL ninth_guess got pulses=%0d ready=%0d turn=%0d want 0 0 8", pulses, gif.guess_ready, turn);
    end
  endtask

  task automatic test_abort();
    int pulses, lat;
    load_code('{1, 2, 3, 4});
    gif.guess0 = 3'd1; gif.guess1 = 3'd2; gif.guess2 = 3'd3; gif.guess3 = 3'd4;
    gif.guess_valid = 1'b1;
    @(posedge clk); #1;              // accept edge T
    gif.guess_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    code_load = 1'b1;                // sampled at T+3, state COLOR
    @(posedge clk); #1;
    code_load = 1'b0;
    total++;
    if (gif.guess_ready !== 1'b1 || turn !== 4'd0 || game_won !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL abort_state got ready=%0d turn=%0d won=%0d rv=%0d want 1 0 0 0",
                      gif.guess_ready, turn, game_won, result_valid);
    end
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (result_valid) pulses++; end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL abort_no_result got %0d pulses want 0", pulses); end
    // Leave nonzero results visible, then reset during EXACT of the next guess.
    do_guess('{1, 2, 4, 3}, lat);
    total++;
    if (exact_cnt !== 3'd2 || color_cnt !== 3'd2 || turn !== 4'd1) begin
      bad++; $display("FAIL pre_reset got ex=%0d col=%0d turn=%0d want 2 2 1", exact_cnt, color_cnt, turn);
    end
    gif.guess_valid = 1'b1;
    @(posedge clk); #1;
    gif.guess_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    total++;
    if ({result_valid, exact_cnt, color_cnt, fb3, fb2, fb1, fb0, turn, game_won, game_over, gif.guess_ready} !== '0) begin
      bad++; $display("FAIL mid_reset got ex=%0d col=%0d fb=%h turn=%0d ready=%0d want all 0",
                      exact_cnt, color_cnt, {fb3, fb2, fb1, fb0}, turn, gif.guess_ready);
    end
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (result_valid || gif.guess_ready) pulses++; end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL post_reset_idle got %0d active cycles want 0", pulses); end
    load_code('{1, 2, 3, 4});
    total++;
    if (gif.guess_ready !== 1'b1) begin bad++; $display("FAIL reload_ready got %0d want 1", gif.guess_ready); end
  endtask

  task automatic test_back_to_back();
    int c[4], g[4], ex, col, pulses, k; logic [7:0] efb;
    c = '{1, 1, 2, 2}; g = '{1, 2, 1, 5};
    model_score(c, g, ex, col, efb);
    load_code(c);
    gif.guess0 = 3'(g[0]); gif.guess1 = 3'(g[1]); gif.guess2 = 3'(g[2]); gif.guess3 = 3'(g[3]);
    gif.guess_valid = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 28; n++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        pulses++;
        total++;
        if (n !== 7 * pulses || exact_cnt !== 3'(ex) || color_cnt !== 3'(col) || turn !== 4'(pulses)) begin
          bad++; $display("FAIL b2b_pulse_%0d got cycle=%0d ex=%0d col=%0d turn=%0d want cycle=%0d ex=%0d col=%0d turn=%0d",
                          pulses, n, exact_cnt, color_cnt, turn, 7 * pulses, ex, col, pulses);
        end
      end
    end
    gif.guess_valid = 1'b0;
    k = 0;
    repeat (10) begin @(posedge clk); #1; if (result_valid) k++; end
    total++;
    if (pulses !== 4 || k !== 0 || turn !== 4'd4) begin
      bad++; $display("FAIL b2b_total got pulses=%0d extra=%0d turn=%0d want 4 0 4", pulses, k, turn);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_turn_limit();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
